bootloader_host_arbiter: RTL and testbench

Shares the single bootloader command FSM between two host transports: host 0 is the I2C slave path and host 1 is the UART path. It grants one host ownership for a complete command/response transaction and routes that host's byte streams to and from the bootloader. It issues the bootloader reset at each grant and each new command. Ownership is released on an explicit end-of-transaction pulse or an inactivity timeout, and a pending request from the other host is then serviced.

---
 rtl/bootloader_host_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_bootloader_host_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bootloader_host_arbiter.sv
// Grants the shared bootloader to the I2C (host 0) or UART (host 1) transport for a whole transaction.
// Datapath is combinational pass-through; grant, bl_reset and pending change one edge after the request.
module bootloader_host_arbiter #(
  parameter int TIMEOUT_CYCLES = 1200000,
  parameter int TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       h0_start,
  input  logic       h1_start,
  input  logic       h0_release,
  input  logic       h1_release,
  input  logic       h0_in_valid,
  input  logic       h1_in_valid,
  input  logic [7:0] h0_in_data,
  input  logic [7:0] h1_in_data,
  output logic       h0_in_ready,
  output logic       h1_in_ready,
  output logic       h0_out_valid,
  output logic       h1_out_valid,
  output logic [7:0] h0_out_data,
  output logic [7:0] h1_out_data,
  input  logic       h0_out_ready,
  input  logic       h1_out_ready,
  output logic       h0_granted,
  output logic       h1_granted,
  output logic       h0_pending,
  output logic       h1_pending,
  output logic       bl_reset,
  output logic       bl_in_valid,
  output logic [7:0] bl_in_data,
  input  logic       bl_in_ready,
  input  logic       bl_out_valid,
  input  logic [7:0] bl_out_data,
  output logic       bl_out_ready,
  input  logic       bl_busy
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, DRAIN} state_t;

  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_d;
  logic          owner, owner_d;
  logic          rr_prio, rr_prio_d;
  logic [1:0]    pending, pending_d;
  logic [TW-1:0] timer, timer_d;
  logic          bl_reset_d;

  logic       owned;
  logic       other;
  logic [1:0] start_v;
  logic [1:0] rel_v;
  logic       in_hs;
  logic       out_hs;
  logic       own_start;
  logic       own_release;
  logic       quiet;
  logic       timeout;
  logic       other_req;
  logic       leave;
  logic       winner;

  assign owned   = (state != IDLE);
  assign other   = ~owner;
  assign start_v = {h1_start, h0_start};
  assign rel_v   = {h1_release, h0_release};

  // Owner's streams pass straight through; in IDLE stray bootloader output is swallowed.
  always_comb begin
    bl_in_valid  = 1'b0;
    bl_in_data   = 8'h00;
    bl_out_ready = 1'b1;
    h0_in_ready  = 1'b0;
    h1_in_ready  = 1'b0;
    h0_out_valid = 1'b0;
    h1_out_valid = 1'b0;
    h0_out_data  = 8'h00;
    h1_out_data  = 8'h00;
    if (owned) begin
      if (owner) begin
        bl_in_valid  = h1_in_valid;
        bl_in_data   = h1_in_data;
        h1_in_ready  = bl_in_ready;
        h1_out_valid = bl_out_valid;
        h1_out_data  = bl_out_data;
        bl_out_ready = h1_out_ready;
      end else begin
        bl_in_valid  = h0_in_valid;
        bl_in_data   = h0_in_data;
        h0_in_ready  = bl_in_ready;
        h0_out_valid = bl_out_valid;
        h0_out_data  = bl_out_data;
        bl_out_ready = h0_out_ready;
      end
    end
  end

  assign in_hs       = owned & bl_in_valid & bl_in_ready;
  assign out_hs      = owned & bl_out_valid & bl_out_ready;
  assign own_start   = owned & start_v[owner];
  assign own_release = owned & rel_v[owner];
  assign quiet       = ~(in_hs | out_hs | own_start | bl_busy);
  assign timeout     = ((state == OWN0) | (state == OWN1)) & quiet & (timer == TIMER_MAX);
  assign other_req   = pending[other] | start_v[other];

  always_comb begin
    state_d    = state;
    owner_d    = owner;
    rr_prio_d  = rr_prio;
    pending_d  = pending;
    timer_d    = timer;
    bl_reset_d = 1'b0;
    leave      = 1'b0;
    winner     = 1'b0;
    case (state)
      IDLE: begin
        if (|start_v) begin
          winner     = (&start_v) ? rr_prio : h1_start;
          state_d    = winner ? OWN1 : OWN0;
          owner_d    = winner;
          bl_reset_d = 1'b1;
          timer_d    = '0;
          if (&start_v) pending_d[~winner] = 1'b1;
        end
      end
      OWN0, OWN1: begin
        pending_d[other] = pending[other] | start_v[other];
        // A restart from the owner outranks its own release in the same cycle.
        if (own_start) begin
          bl_reset_d = 1'b1;
          timer_d    = '0;
        end else if (own_release | timeout) begin
          if (bl_busy) begin
            state_d = DRAIN;
            timer_d = '0;
          end else begin
            leave = 1'b1;
          end
        end else if (!quiet) begin
          timer_d = '0;
        end else if (timer != TIMER_MAX) begin
          timer_d = timer + 1'b1;
        end
      end
      DRAIN: begin
        pending_d[other] = pending[other] | start_v[other];
        if (own_start) begin
          state_d    = owner ? OWN1 : OWN0;
          bl_reset_d = 1'b1;
          timer_d    = '0;
        end else if (!bl_busy) begin
          leave = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Hand over directly to a waiting host, otherwise fall back to IDLE.
    if (leave) begin
      timer_d = '0;
      if (other_req) begin
        state_d          = other ? OWN1 : OWN0;
        owner_d          = other;
        pending_d[other] = 1'b0;
        rr_prio_d        = owner;
        bl_reset_d       = 1'b1;
      end else begin
        state_d   = IDLE;
        rr_prio_d = other;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      owner    <= 1'b0;
      rr_prio  <= 1'b0;
      pending  <= 2'b00;
      timer    <= '0;
      bl_reset <= 1'b0;
    end else begin
      state    <= state_d;
      owner    <= owner_d;
      rr_prio  <= rr_prio_d;
      pending  <= pending_d;
      timer    <= timer_d;
      bl_reset <= bl_reset_d;
    end
  end

  assign h0_granted = (state == OWN0) | ((state == DRAIN) & ~owner);
  assign h1_granted = (state == OWN1) | ((state == DRAIN) & owner);
  assign h0_pending = pending[0];
  assign h1_pending = pending[1];

endmodule

// File: tb/tb_bootloader_host_arbiter.sv
// Directed scenarios followed by randomized traffic, all checked against a transaction-level model.
module tb_bootloader_host_arbiter;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       resetn;
  logic [1:0] start;
  logic [1:0] rel;
  logic [1:0] in_valid;
  logic [7:0] in_data [2];
  logic [1:0] out_ready;
  logic       bl_in_ready;
  logic       bl_out_valid;
  logic [7:0] bl_out_data;
  logic       bl_busy;

  logic       h0_in_ready, h1_in_ready, h0_out_valid, h1_out_valid;
  logic [7:0] h0_out_data, h1_out_data;
  logic       h0_granted, h1_granted, h0_pending, h1_pending;
  logic       bl_reset, bl_in_valid, bl_out_ready;
  logic [7:0] bl_in_data;

  always #5 clk = ~clk;

  bootloader_host_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .resetn(resetn),
    .h0_start(start[0]), .h1_start(start[1]),
    .h0_release(rel[0]), .h1_release(rel[1]),
    .h0_in_valid(in_valid[0]), .h1_in_valid(in_valid[1]),
    .h0_in_data(in_data[0]), .h1_in_data(in_data[1]),
    .h0_in_ready(h0_in_ready), .h1_in_ready(h1_in_ready),
    .h0_out_valid(h0_out_valid), .h1_out_valid(h1_out_valid),
    .h0_out_data(h0_out_data), .h1_out_data(h1_out_data),
    .h0_out_ready(out_ready[0]), .h1_out_ready(out_ready[1]),
    .h0_granted(h0_granted), .h1_granted(h1_granted),
    .h0_pending(h0_pending), .h1_pending(h1_pending),
    .bl_reset(bl_reset),
    .bl_in_valid(bl_in_valid), .bl_in_data(bl_in_data), .bl_in_ready(bl_in_ready),
    .bl_out_valid(bl_out_valid), .bl_out_data(bl_out_data), .bl_out_ready(bl_out_ready),
    .bl_busy(bl_busy)
  );

  int checks = 0;
  int errors = 0;

  // Model: owner as -1/0/1, a draining flag, and a run-length of consecutive quiet owned cycles.
  int       m_own;
  bit       m_drain;
  int       m_run;
  bit [1:0] m_pend;
  int       m_prio;
  bit       m_rst;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_own = -1; m_drain = 0; m_run = 0; m_pend = 2'b00; m_prio = 0; m_rst = 0;
  endfunction

  function automatic void m_leave(input int o, input int x);
    if (m_pend[x]) begin
      m_own = x; m_pend[x] = 1'b0; m_prio = o; m_rst = 1;
    end else begin
      m_own = -1; m_prio = x;
    end
    m_run = 0; m_drain = 0;
  endfunction

  task automatic m_step();
    int o, x;
    bit quiet;
    if (!resetn) begin m_reset(); return; end
    m_rst = 0;
    if (m_own < 0) begin
      if (start != 2'b00) begin
        o = (start == 2'b11) ? m_prio : (start[1] ? 1 : 0);
        m_own = o; m_rst = 1; m_run = 0; m_drain = 0;
        if (start == 2'b11) m_pend[1-o] = 1'b1;
      end
      return;
    end
    o = m_own; x = 1 - o;
    if (start[x]) m_pend[x] = 1'b1;
    quiet = !((in_valid[o] && bl_in_ready) || (bl_out_valid && out_ready[o]) || start[o] || bl_busy);
    if (start[o]) begin m_rst = 1; m_run = 0; m_drain = 0; return; end
    if (m_drain) begin
      if (!bl_busy) m_leave(o, x);
      return;
    end
    m_run = quiet ? m_run + 1 : 0;
    if (rel[o] || m_run >= T) begin
      if (bl_busy) begin m_drain = 1; m_run = 0; end
      else m_leave(o, x);
    end
  endtask

  task automatic check_all();
    logic [1:0] d_in_ready, d_out_valid;
    logic [7:0] d_out_data [2];
    int o;
    d_in_ready  = {h1_in_ready, h0_in_ready};
    d_out_valid = {h1_out_valid, h0_out_valid};
    d_out_data[0] = h0_out_data;
    d_out_data[1] = h1_out_data;
    chk1("h0_granted", h0_granted, m_own == 0);
    chk1("h1_granted", h1_granted, m_own == 1);
    chk1("h0_pending", h0_pending, m_pend[0]);
    chk1("h1_pending", h1_pending, m_pend[1]);
    chk1("bl_reset", bl_reset, m_rst);
    if (m_own < 0) begin
      chk1("idle_bl_in_valid", bl_in_valid, 1'b0);
      chk1("idle_bl_out_ready", bl_out_ready, 1'b1);
      chk8("idle_in_ready", {6'd0, d_in_ready}, 8'h00);
      chk8("idle_out_valid", {6'd0, d_out_valid}, 8'h00);
      chk8("idle_h0_out_data", h0_out_data, 8'h00);
      chk8("idle_h1_out_data", h1_out_data, 8'h00);
    end else begin
      o = m_own;
      chk1("bl_in_valid", bl_in_valid, in_valid[o]);
      chk8("bl_in_data", bl_in_data, in_data[o]);
      chk1("bl_out_ready", bl_out_ready, out_ready[o]);
      chk1("owner_in_ready", d_in_ready[o], bl_in_ready);
      chk1("other_in_ready", d_in_ready[1-o], 1'b0);
      chk1("owner_out_valid", d_out_valid[o], bl_out_valid);
      chk8("owner_out_data", d_out_data[o], bl_out_data);
      chk1("other_out_valid", d_out_valid[1-o], 1'b0);
      chk8("other_out_data", d_out_data[1-o], 8'h00);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic idle_inputs();
    start = 2'b00; rel = 2'b00; in_valid = 2'b00;
    in_data[0] = 8'h00; in_data[1] = 8'h00;
    out_ready = 2'b00; bl_in_ready = 1'b0;
    bl_out_valid = 1'b0; bl_out_data = 8'h00; bl_busy = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    m_reset();
    cycle();
    cycle();
    resetn = 1'b1;
    cycle();
  endtask

  initial begin
    int n;
    bit busy_state;
    bit sparse;
    idle_inputs();
    resetn = 1'b0;
    m_reset();
    #1;
    chk1("rst_h0_granted", h0_granted, 1'b0);
    chk1("rst_h1_granted", h1_granted, 1'b0);
    chk1("rst_bl_reset", bl_reset, 1'b0);
    do_reset();

    // Single host, two bytes into the bootloader.
    start[0] = 1'b1; in_valid[1] = 1'b1; in_data[1] = 8'hEE;
    cycle();
    start[0] = 1'b0; in_valid[0] = 1'b1; in_data[0] = 8'h01; bl_in_ready = 1'b1;
    #1;
    chk1("t1_reset_pulse", bl_reset, 1'b1);
    chk1("t1_granted", h0_granted, 1'b1);
    chk8("t1_byte0", bl_in_data, 8'h01);
    chk1("t1_h1_in_ready", h1_in_ready, 1'b0);
    cycle();
    in_data[0] = 8'h02;
    #1;
    chk8("t1_byte1", bl_in_data, 8'h02);
    chk1("t1_pulse_done", bl_reset, 1'b0);
    chk1("t1_h1_in_ready2", h1_in_ready, 1'b0);
    cycle();
    idle_inputs();
    rel[0] = 1'b1;
    cycle();
    rel[0] = 1'b0;
    chk1("t1_released", h0_granted, 1'b0);
    cycle();

    // Simultaneous starts and round-robin return.
    do_reset();
    start = 2'b11;
    cycle();
    start = 2'b00;
    chk1("t2_h0_wins", h0_granted, 1'b1);
    chk1("t2_h1_pending", h1_pending, 1'b1);
    cycle();
    rel[0] = 1'b1;
    cycle();
    rel[0] = 1'b0;
    chk1("t2_h1_granted", h1_granted, 1'b1);
    chk1("t2_handover_pulse", bl_reset, 1'b1);
    chk1("t2_h1_pending_clr", h1_pending, 1'b0);
    cycle();
    rel[1] = 1'b1;
    cycle();
    rel[1] = 1'b0;
    chk1("t2_h1_released", h1_granted, 1'b0);
    cycle();
    start = 2'b11;
    cycle();
    start = 2'b00;
    chk1("t2_h0_wins_again", h0_granted, 1'b1);
    cycle();

    // Inactivity timeout measured from the last handshake.
    do_reset();
    start[1] = 1'b1;
    cycle();
    start[1] = 1'b0; in_valid[1] = 1'b1; in_data[1] = 8'h55; bl_in_ready = 1'b1;
    cycle();
    in_valid[1] = 1'b0; bl_in_ready = 1'b0;
    n = 0;
    while (h1_granted && n < 40) begin
      cycle();
      n++;
    end
    chk8("t3_timeout_edges", 8'(n), 8'd16);
    chk1("t3_idle_out_ready", bl_out_ready, 1'b1);
    cycle();

    // Release while the bootloader is busy drains first.
    do_reset();
    start[0] = 1'b1;
    cycle();
    start[0] = 1'b0; bl_busy = 1'b1;
    for (int i = 0; i < 50; i++) begin
      rel[0] = (i == 5);
      cycle();
      chk1("t4_held_busy", h0_granted, 1'b1);
    end
    rel[0] = 1'b0; bl_busy = 1'b0;
    #1;
    chk1("t4_held_last", h0_granted, 1'b1);
    cycle();
    chk1("t4_released", h0_granted, 1'b0);
    cycle();

    // Output backpressure, then discard in IDLE.
    do_reset();
    start[0] = 1'b1;
    cycle();
    start[0] = 1'b0; bl_out_valid = 1'b1; bl_out_data = 8'hA5; out_ready = 2'b10;
    #1;
    chk1("t5_backpressure", bl_out_ready, 1'b0);
    chk1("t5_h0_out_valid", h0_out_valid, 1'b1);
    chk8("t5_h0_out_data", h0_out_data, 8'hA5);
    chk1("t5_h1_out_valid", h1_out_valid, 1'b0);
    cycle(); cycle(); cycle();
    rel[0] = 1'b1;
    cycle();
    rel[0] = 1'b0;
    chk1("t5_released", h0_granted, 1'b0);
    chk1("t5_idle_discard", bl_out_ready, 1'b1);
    cycle();

    // Asynchronous reset mid-transfer.
    do_reset();
    start[1] = 1'b1;
    cycle();
    start = 2'b01;
    cycle();
    start = 2'b00; in_valid[1] = 1'b1; in_data[1] = 8'h3C; bl_in_ready = 1'b1;
    cycle();
    chk1("t6_h0_pending", h0_pending, 1'b1);
    cycle();
    #2;
    resetn = 1'b0;
    m_reset();
    #1;
    chk1("t6_h0_granted", h0_granted, 1'b0);
    chk1("t6_h1_granted", h1_granted, 1'b0);
    chk1("t6_h0_pending", h0_pending, 1'b0);
    chk1("t6_h1_pending", h1_pending, 1'b0);
    chk1("t6_bl_reset", bl_reset, 1'b0);
    cycle();
    resetn = 1'b1;
    idle_inputs();
    cycle();
    chk1("t6_no_pulse", bl_reset, 1'b0);

    // Randomized traffic: alternating dense and sparse windows so timeouts also occur.
    busy_state = 1'b0;
    sparse = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 150 == 0) sparse = ~sparse;
      if ($urandom_range(0, 699) == 0) begin
        resetn = 1'b0;
        m_reset();
      end else begin
        resetn = 1'b1;
      end
      if (busy_state) busy_state = ($urandom_range(0, 7) != 0);
      else            busy_state = ($urandom_range(0, 39) == 0);
      bl_busy = busy_state;
      for (int h = 0; h < 2; h++) begin
        start[h]     = ($urandom_range(0, 24) == 0);
        rel[h]       = ($urandom_range(0, 19) == 0);
        in_valid[h]  = sparse ? ($urandom_range(0, 29) == 0) : $urandom_range(0, 1) == 1;
        in_data[h]   = 8'($urandom);
        out_ready[h] = $urandom_range(0, 1) == 1;
      end
      bl_in_ready  = $urandom_range(0, 1) == 1;
      bl_out_valid = sparse ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 2) == 0);
      bl_out_data  = 8'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
